mem_access_stage: RTL and testbench

Memory-access stage of the 5-stage RISC-V core: consumes the registered ALU result (effective address or pass-through result) plus store data and control from the EX/MEM boundary. It performs loads and stores on a single-outstanding req/ack data-memory port and hands a registered result to writeback. Non-memory instructions pass through with one cycle of latency; memory instructions stall upstream until the bus completes.

---
 rtl/mem_access_stage_pkg.sv | 62 ++++++
 rtl/mem_access_stage_load_extend.sv | 34 +++
 rtl/mem_access_stage.sv | 190 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, FSM states,
// lane widths and helpers that map funct3 to an access size.
// Purely declarative; no logic or timing of its own.
package riscv_mem_pkg;

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Lane geometry of the data bus
  localparam int XLEN   = 32;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int LANES  = XLEN / BYTE_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Undefined load encodings behave as LW
  function automatic size_e load_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: load_size = SZ_BYTE;
      F3_LH, F3_LHU: load_size = SZ_HALF;
      default:       load_size = SZ_WORD;
    endcase
  endfunction

  // Undefined store encodings behave as SW
  function automatic size_e store_size(input logic [2:0] f3);
    case (f3)
      F3_SB:   store_size = SZ_BYTE;
      F3_SH:   store_size = SZ_HALF;
      default: store_size = SZ_WORD;
    endcase
  endfunction

  // Clear the low offset bits that a naturally aligned access of this size cannot use
  function automatic logic [1:0] align_off(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: align_off = off;
      SZ_HALF: align_off = {off[1], 1'b0};
      default: align_off = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Selects the addressed byte/halfword of a load word and sign/zero extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs directly.
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  // Lane pick by byte offset, then extension chosen by funct3
  always_comb begin
    case (off_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      F3_LH:   data_o = {{(XLEN-HALF_W){half_sel[HALF_W-1]}}, half_sel};
      F3_LBU:  data_o = {{(XLEN-BYTE_W){1'b0}}, byte_sel};
      F3_LHU:  data_o = {{(XLEN-HALF_W){1'b0}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RISC-V memory-access stage: pass-through ALU results, loads/stores over a req/ack port.
// Latency: 1 cycle for non-memory ops; ack cycle + 1 for memory ops (bus timeout aborts).
// Backpressure: in_ready only in IDLE; low while a bus access is outstanding.
// Build option MISALIGN_TRAP_EN: trap misaligned halfword/word accesses instead of masking.
module mem_access_stage
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        wb_err,
  output logic        wb_misalign
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e         state_q;
  logic [TW-1:0]  tmo_q;
  logic           dmem_req_q, dmem_we_q;
  logic [31:0]    dmem_addr_q, dmem_wdata_q;
  logic [3:0]     dmem_wstrb_q;
  logic [2:0]     funct3_q;
  logic [1:0]     off_q;
  logic [4:0]     rd_q;
  logic           rw_q;
  logic           wb_valid_q, wb_reg_write_q, wb_err_q, wb_misalign_q;
  logic [31:0]    wb_data_q;
  logic [4:0]     wb_rd_q;

  logic           is_mem;
  size_e          acc_size;
  logic [1:0]     off_raw, off_al;
  logic           misalign_hit;
  logic [3:0]     wstrb_d;
  logic [31:0]    wdata_d;
  logic [31:0]    ld_data;
  logic           tmo_hit;

  assign in_ready = (state_q == ST_IDLE);
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

  // Decode size, aligned lane offset, byte enables and replicated store data
  always_comb begin
    is_mem   = mem_read | mem_write;
    acc_size = mem_write ? store_size(funct3) : load_size(funct3);
    off_raw  = alu_result[1:0];
    off_al   = align_off(acc_size, off_raw);
`ifdef MISALIGN_TRAP_EN
    misalign_hit = is_mem && (off_al != off_raw);
`else
    misalign_hit = 1'b0;
`endif
    case (acc_size)
      SZ_BYTE: begin
        wstrb_d = 4'b0001 << off_al;
        wdata_d = {LANES{store_data[7:0]}};
      end
      SZ_HALF: begin
        wstrb_d = 4'b0011 << off_al;
        wdata_d = {2{store_data[15:0]}};
      end
      default: begin
        wstrb_d = 4'hF;
        wdata_d = store_data;
      end
    endcase
  end

  load_extend u_load_extend (
    .rdata_i  (dmem_rdata),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .data_o   (ld_data)
  );

  // IDLE/BUS control with registered bus and writeback outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      tmo_q          <= '0;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      dmem_addr_q    <= '0;
      dmem_wdata_q   <= '0;
      dmem_wstrb_q   <= '0;
      funct3_q       <= '0;
      off_q          <= '0;
      rd_q           <= '0;
      rw_q           <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      wb_err_q       <= 1'b0;
      wb_misalign_q  <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (!is_mem || misalign_hit) begin
              // Retire directly: pass-through result or misalignment trap
              wb_valid_q     <= 1'b1;
              wb_data_q      <= alu_result;
              wb_rd_q        <= rd;
              wb_reg_write_q <= reg_write & ~misalign_hit;
              wb_err_q       <= 1'b0;
              wb_misalign_q  <= misalign_hit;
            end else begin
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= mem_write;
              dmem_addr_q  <= {alu_result[31:2], 2'b00};
              dmem_wdata_q <= mem_write ? wdata_d : 32'h0;
              dmem_wstrb_q <= mem_write ? wstrb_d : 4'h0;
              funct3_q     <= funct3;
              off_q        <= off_al;
              rd_q         <= rd;
              rw_q         <= reg_write & ~mem_write;
              tmo_q        <= '0;
              state_q      <= ST_BUS;
            end
          end
        end
        default: begin
          // An ack on the expiry cycle still completes normally
          if (dmem_ack) begin
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_wstrb_q   <= 4'h0;
            wb_valid_q     <= 1'b1;
            wb_data_q      <= dmem_we_q ? 32'h0 : ld_data;
            wb_rd_q        <= rd_q;
            wb_reg_write_q <= rw_q;
            wb_err_q       <= 1'b0;
            wb_misalign_q  <= 1'b0;
            state_q        <= ST_IDLE;
          end else if (tmo_hit) begin
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_wstrb_q   <= 4'h0;
            wb_valid_q     <= 1'b1;
            wb_data_q      <= 32'h0;
            wb_rd_q        <= rd_q;
            wb_reg_write_q <= 1'b0;
            wb_err_q       <= 1'b1;
            wb_misalign_q  <= 1'b0;
            state_q        <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign dmem_wstrb   = dmem_wstrb_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_err       = wb_err_q;
  assign wb_misalign  = wb_misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through, loads, stores, timeout,
// misalignment and reset during an outstanding access.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [2:0]  funct3;
  logic        mem_read, mem_write;
  logic [4:0]  rd;
  logic        reg_write;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, wb_err, wb_misalign;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .funct3       (funct3),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .rd           (rd),
    .reg_write    (reg_write),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wstrb   (dmem_wstrb),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .wb_err       (wb_err),
    .wb_misalign  (wb_misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accepting edge
  task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] f3,
                       input logic [4:0] d, input logic rw, input logic mr, input logic mw);
    alu_result = a;
    store_data = sd;
    funct3     = f3;
    rd         = d;
    reg_write  = rw;
    mem_read   = mr;
    mem_write  = mw;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
  endtask

  // Memory op with a given number of wait cycles before ack
  task automatic mem_op(input string tag, input logic [31:0] a, input logic [31:0] sd,
                        input logic [2:0] f3, input logic mw, input int waits,
                        input logic [31:0] rdata, input logic [31:0] exp_addr,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wb, input logic exp_rw);
    issue(a, sd, f3, 5'd9, 1'b1, ~mw, mw);
    check({tag, ".req"}, {31'b0, dmem_req}, 32'd1);
    check({tag, ".addr"}, dmem_addr, exp_addr);
    check({tag, ".we"}, {31'b0, dmem_we}, {31'b0, mw});
    check({tag, ".rdy_busy"}, {31'b0, in_ready}, 32'd0);
    if (mw) begin
      check({tag, ".wdata"}, dmem_wdata, exp_wdata);
      check({tag, ".wstrb"}, {28'b0, dmem_wstrb}, {28'b0, exp_strb});
    end
    repeat (waits) tick();
    check({tag, ".req_held"}, {31'b0, dmem_req}, 32'd1);
    check({tag, ".wb_early"}, {31'b0, wb_valid}, 32'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    check({tag, ".wb_valid"}, {31'b0, wb_valid}, 32'd1);
    if (!mw) check({tag, ".wb_data"}, wb_data, exp_wb);
    check({tag, ".wb_rw"}, {31'b0, wb_reg_write}, {31'b0, exp_rw});
    check({tag, ".wb_rd"}, {27'b0, wb_rd}, 32'd9);
    check({tag, ".wb_err"}, {31'b0, wb_err}, 32'd0);
    check({tag, ".req_drop"}, {31'b0, dmem_req}, 32'd0);
    check({tag, ".rdy"}, {31'b0, in_ready}, 32'd1);
    tick();
    check({tag, ".pulse"}, {31'b0, wb_valid}, 32'd0);
  endtask

  initial begin
    int k;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    alu_result = 32'h0;
    store_data = 32'h0;
    funct3     = 3'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    rd         = 5'd0;
    reg_write  = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    #12;
    check("rst.req",    {31'b0, dmem_req}, 32'd0);
    check("rst.we",     {31'b0, dmem_we}, 32'd0);
    check("rst.addr",   dmem_addr, 32'h0);
    check("rst.wdata",  dmem_wdata, 32'h0);
    check("rst.wstrb",  {28'b0, dmem_wstrb}, 32'h0);
    check("rst.wb",     {26'b0, wb_valid, wb_reg_write, wb_err, wb_misalign, 2'b0}, 32'h0);
    check("rst.wbdata", wb_data, 32'h0);
    check("rst.wbrd",   {27'b0, wb_rd}, 32'h0);
    check("rst.rdy",    {31'b0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Pass-through ALU result
    issue(32'h0000_1234, 32'h0, 3'b000, 5'd5, 1'b1, 1'b0, 1'b0);
    check("add.wb_valid", {31'b0, wb_valid}, 32'd1);
    check("add.wb_data",  wb_data, 32'h0000_1234);
    check("add.wb_rd",    {27'b0, wb_rd}, 32'd5);
    check("add.wb_rw",    {31'b0, wb_reg_write}, 32'd1);
    check("add.no_req",   {31'b0, dmem_req}, 32'd0);
    check("add.rdy",      {31'b0, in_ready}, 32'd1);
    tick();
    check("add.pulse",    {31'b0, wb_valid}, 32'd0);

    // Loads: tag, addr, sd, f3, mw, waits, rdata, exp_addr, exp_wdata, exp_strb, exp_wb, exp_rw
    mem_op("lb",  32'h103, 32'h0, 3'b000, 1'b0, 2, 32'h80FF_FFFF, 32'h100, 32'h0, 4'h0, 32'hFFFF_FF80, 1'b1);
    mem_op("lbu", 32'h103, 32'h0, 3'b100, 1'b0, 0, 32'h80FF_FFFF, 32'h100, 32'h0, 4'h0, 32'h0000_0080, 1'b1);
    mem_op("lh",  32'h102, 32'h0, 3'b001, 1'b0, 1, 32'h8001_1234, 32'h100, 32'h0, 4'h0, 32'hFFFF_8001, 1'b1);
    mem_op("lhu", 32'h100, 32'h0, 3'b101, 1'b0, 0, 32'h8001_F234, 32'h100, 32'h0, 4'h0, 32'h0000_F234, 1'b1);
    mem_op("lw",  32'h500, 32'h0, 3'b010, 1'b0, 3, 32'h1234_5678, 32'h500, 32'h0, 4'h0, 32'h1234_5678, 1'b1);
    // Stores
    mem_op("sh",  32'h202, 32'h0000_ABCD, 3'b001, 1'b1, 0, 32'h0, 32'h200, 32'hABCD_ABCD, 4'b1100, 32'h0, 1'b0);
    mem_op("sb",  32'h101, 32'h1234_565A, 3'b000, 1'b1, 1, 32'h0, 32'h100, 32'h5A5A_5A5A, 4'b0010, 32'h0, 1'b0);
    mem_op("sw",  32'h400, 32'hDEAD_BEEF, 3'b010, 1'b1, 0, 32'h0, 32'h400, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);

    // Timeout: no ack for 16 bus cycles
    issue(32'h600, 32'h0, 3'b010, 5'd11, 1'b1, 1'b1, 1'b0);
    k = 0;
    while (dmem_req && k < 40) begin
      k++;
      tick();
    end
    check("tmo.cycles",   k, 32'd16);
    check("tmo.wb_valid", {31'b0, wb_valid}, 32'd1);
    check("tmo.wb_err",   {31'b0, wb_err}, 32'd1);
    check("tmo.wb_rw",    {31'b0, wb_reg_write}, 32'd0);
    check("tmo.wb_rd",    {27'b0, wb_rd}, 32'd11);
    check("tmo.rdy",      {31'b0, in_ready}, 32'd1);
    tick();

    // Ack arriving on the expiry cycle completes normally
    issue(32'h700, 32'h0, 3'b010, 5'd12, 1'b1, 1'b1, 1'b0);
    repeat (15) tick();
    check("tmo_ack.req", {31'b0, dmem_req}, 32'd1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    check("tmo_ack.wb_valid", {31'b0, wb_valid}, 32'd1);
    check("tmo_ack.wb_err",   {31'b0, wb_err}, 32'd0);
    check("tmo_ack.wb_data",  wb_data, 32'h0BAD_F00D);
    check("tmo_ack.wb_rw",    {31'b0, wb_reg_write}, 32'd1);
    tick();

    // Misaligned word load
`ifdef MISALIGN_TRAP_EN
    issue(32'h302, 32'h0, 3'b010, 5'd13, 1'b1, 1'b1, 1'b0);
    check("mis.no_req",   {31'b0, dmem_req}, 32'd0);
    check("mis.wb_valid", {31'b0, wb_valid}, 32'd1);
    check("mis.flag",     {31'b0, wb_misalign}, 32'd1);
    check("mis.wb_rw",    {31'b0, wb_reg_write}, 32'd0);
    check("mis.rdy",      {31'b0, in_ready}, 32'd1);
    tick();
`else
    mem_op("mis", 32'h302, 32'h0, 3'b010, 1'b0, 1, 32'hCAFE_F00D, 32'h300, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1);
    check("mis.flag", {31'b0, wb_misalign}, 32'd0);
`endif

    // Reset while an access is outstanding
    issue(32'h800, 32'h0, 3'b010, 5'd14, 1'b1, 1'b1, 1'b0);
    check("rstbus.req", {31'b0, dmem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstbus.req_async", {31'b0, dmem_req}, 32'd0);
    check("rstbus.rdy",       {31'b0, in_ready}, 32'd1);
    tick();
    rst_n      = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    tick();
    check("rstbus.no_wb", {31'b0, wb_valid}, 32'd0);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    tick();
    check("rstbus.no_wb2", {31'b0, wb_valid}, 32'd0);
    check("rstbus.idle",   {31'b0, dmem_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
